// File: rtl/conv1_layer_sched.sv
// conv1 layer sequencer: gates conv1 through conv_en, buffers its output vectors and
// serialises them one channel per beat. Optional CONV1_PERF_CNT_EN adds a stall counter.
module conv1_layer_sched #(
  parameter int OUT_W = 111,
  parameter int OUT_H = 111,
  parameter int CH    = 64,
  parameter int DW    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     conv_en,
  input  logic                     conv_valid,
  input  logic [CH*DW-1:0]         conv_data,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [DW-1:0]            o_data,
  output logic [$clog2(CH)-1:0]    o_ch,
  output logic [$clog2(OUT_H)-1:0] o_row,
  output logic [$clog2(OUT_W)-1:0] o_col,
  output logic                     o_last,
  output logic                     ovf_err
`ifdef CONV1_PERF_CNT_EN
  ,
  output logic [31:0]              stall_cycles
`endif
);

  localparam int TOTAL = OUT_W * OUT_H;
  localparam int PW    = $clog2(TOTAL + 1);
  localparam int CHW   = $clog2(CH);
  localparam int RW    = $clog2(OUT_H);
  localparam int CW    = $clog2(OUT_W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CH*DW-1:0] buf_mem [2];
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       cnt_q, cnt_d;
  logic [PW-1:0]    cap_q, cap_d;
  logic [CHW-1:0]   ch_q;
  logic [RW-1:0]    row_q;
  logic [CW-1:0]    col_q;
  logic             busy_q, done_q, conv_en_q, conv_en_d, ovf_q;

  logic start_acc, push, drop, beat, pop;
  logic pix_end, col_end, row_end;

  assign start_acc = (state_q == S_IDLE) && start;
  assign push      = (state_q == S_RUN) && conv_valid && (cnt_q != 2'd2);
  assign drop      = (state_q == S_RUN) && conv_valid && (cnt_q == 2'd2);
  assign o_valid   = (cnt_q != 2'd0);
  assign beat      = o_valid && o_ready;
  assign pix_end   = (ch_q == CHW'(CH - 1));
  assign col_end   = (col_q == CW'(OUT_W - 1));
  assign row_end   = (row_q == RW'(OUT_H - 1));
  assign pop       = beat && pix_end;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    cap_d = cap_q;
    if (start_acc) begin
      cap_d = '0;
    end else if (push) begin
      cap_d = cap_q + PW'(1);
    end
  end

  // Leave RUN on the edge that captures the final pixel so the last pop always sees DRAIN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cap_d == PW'(TOTAL)) state_d = S_DRAIN;
      S_DRAIN: if (pop && (cnt_q == 2'd1)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request only when the buffer will be empty; the second slot catches the in-flight vector.
  assign conv_en_d = (state_d == S_RUN) && (cnt_d == 2'd0) && (cap_d < PW'(TOTAL));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      conv_en_q <= 1'b0;
      cnt_q     <= 2'd0;
      cap_q     <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      ch_q      <= '0;
      row_q     <= '0;
      col_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_DONE);
      conv_en_q <= conv_en_d;
      cnt_q     <= cnt_d;
      cap_q     <= cap_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      if (start_acc) begin
        ch_q  <= '0;
        row_q <= '0;
        col_q <= '0;
      end else if (beat) begin
        ch_q <= pix_end ? '0 : ch_q + CHW'(1);
        if (pix_end) begin
          if (col_end) begin
            col_q <= '0;
            row_q <= row_end ? '0 : row_q + RW'(1);
          end else begin
            col_q <= col_q + CW'(1);
          end
        end
      end
      if (start_acc) begin
        ovf_q <= 1'b0;
      end else if (drop) begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) buf_mem[wr_ptr_q] <= conv_data;
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign conv_en = conv_en_q;
  assign ovf_err = ovf_q;
  assign o_data  = o_valid ? buf_mem[rd_ptr_q][ch_q*DW +: DW] : '0;
  assign o_ch    = ch_q;
  assign o_row   = row_q;
  assign o_col   = col_q;
  assign o_last  = o_valid && pix_end && row_end && col_end;

`ifdef CONV1_PERF_CNT_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (start_acc) begin
      stall_q <= '0;
    end else if (busy_q && o_valid && !o_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_conv1_layer_sched.sv
// Directed bench for conv1_layer_sched on a 3x2x4 frame with a scoreboard of expected beats.
module tb_conv1_layer_sched;
  localparam int W     = 3;
  localparam int H     = 2;
  localparam int CH    = 4;
  localparam int DW    = 16;
  localparam int TOTAL = W * H;
  localparam int CHW   = $clog2(CH);
  localparam int RW    = $clog2(H);
  localparam int CW    = $clog2(W);
  localparam int EW    = DW + CHW + RW + CW + 1;

  logic              clk = 1'b0;
  logic              rst, start, conv_valid, o_ready;
  logic [CH*DW-1:0]  conv_data;
  logic              busy, done, conv_en, o_valid, o_last, ovf_err;
  logic [DW-1:0]     o_data;
  logic [CHW-1:0]    o_ch;
  logic [RW-1:0]     o_row;
  logic [CW-1:0]     o_col;
`ifdef CONV1_PERF_CNT_EN
  logic [31:0]       stall_cycles;
`endif

  always #5 clk = ~clk;

  conv1_layer_sched #(.OUT_W(W), .OUT_H(H), .CH(CH), .DW(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .conv_en    (conv_en),
    .conv_valid (conv_valid),
    .conv_data  (conv_data),
    .o_valid    (o_valid),
    .o_ready    (o_ready),
    .o_data     (o_data),
    .o_ch       (o_ch),
    .o_row      (o_row),
    .o_col      (o_col),
    .o_last     (o_last),
    .ovf_err    (ovf_err)
`ifdef CONV1_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  int total_cnt = 0;
  int bad_cnt   = 0;
  logic [EW-1:0] sb [$];
  int cyc = 0, last_cyc = -10, done_cnt = 0, beats_seen = 0, pix_idx = 0, frame_tag = 0;
  bit conv_on = 1'b0, rand_rdy = 1'b0, en_seen = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total_cnt++;
    assert (obs === expv) else begin
      bad_cnt++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [DW-1:0] golden(input int idx, input int c);
    return DW'(frame_tag * 4096 + idx * 16 + c);
  endfunction

  function automatic logic [CH*DW-1:0] pix_vec(input int idx);
    logic [CH*DW-1:0] v;
    v = '0;
    for (int c = 0; c < CH; c++) v[c*DW +: DW] = golden(idx, c);
    return v;
  endfunction

  task automatic push_exp(input int idx);
    for (int c = 0; c < CH; c++) begin
      sb.push_back({golden(idx, c), CHW'(c), RW'(idx / W), CW'(idx % W),
                    (idx == TOTAL - 1) && (c == CH - 1)});
    end
  endtask

  // Sample at the falling edge, then drive next-cycle inputs just after the rising edge.
  task automatic tick();
    logic [EW-1:0] obs;
    @(negedge clk);
    en_seen = conv_en;
    if (o_valid && o_ready) begin
      obs = {o_data, o_ch, o_row, o_col, o_last};
      if (sb.size() == 0) chk("beat_unexpected", 64'(obs), 64'hDEAD);
      else                chk("beat", 64'(obs), 64'(sb.pop_front()));
      $display("beat t=%0d r=%0d c=%0d ch=%0d data=%h last=%0b", cyc, o_row, o_col, o_ch, o_data, o_last);
      beats_seen++;
      if (o_last) last_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      chk("done_latency", cyc, last_cyc + 1);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rand_rdy) o_ready = 1'($urandom_range(0, 1));
    if (conv_on) begin
      conv_valid = en_seen;
      if (en_seen) begin
        conv_data = pix_vec(pix_idx);
        if (pix_idx < TOTAL) push_exp(pix_idx);
        pix_idx++;
      end
    end
  endtask

  task automatic do_start();
    pix_idx = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("busy_on_start", busy, 1);
    chk("conv_en_on_start", conv_en, 1);
  endtask

  task automatic run_until_done(input int max_cyc);
    int d0;
    d0 = done_cnt;
    for (int n = 0; n < max_cyc && done_cnt == d0; n++) tick();
    chk("frame_done", done_cnt - d0, 1);
    chk("busy_after_done", busy, 0);
  endtask

  task automatic frame_checks(input int b0);
    chk("beat_count", beats_seen - b0, CH * TOTAL);
    chk("sb_empty", sb.size(), 0);
    chk("ovf_clear", ovf_err, 0);
  endtask

  initial begin
    int b0, d0;
    logic [DW-1:0] sd;
    logic [CHW-1:0] sc;
    rst = 1'b1; start = 1'b0; conv_valid = 1'b0; conv_data = '0; o_ready = 1'b1;
    repeat (3) tick();
    chk("reset_outputs", {busy, done, conv_en, o_valid, o_last, ovf_err, o_data, o_ch, o_row, o_col}, '0);
    rst = 1'b0;
    tick();
    chk("idle_after_reset", {busy, conv_en, o_valid}, 0);

    // Frame 1: always ready.
    conv_on = 1'b1; frame_tag = 1; b0 = beats_seen;
    do_start();
    run_until_done(500);
    frame_checks(b0);

    // Frame 2: 10-cycle stall mid-pixel, plus a start pulse while busy.
    frame_tag = 2; b0 = beats_seen;
    do_start();
    for (int n = 0; n < 300 && beats_seen - b0 < 6; n++) tick();
    chk("reach_stall_point", beats_seen - b0, 6);
    o_ready = 1'b0;
    sd = o_data;
    sc = o_ch;
    for (int k = 0; k < 10; k++) begin
      if (k == 3) start = 1'b1;
      tick();
      start = 1'b0;
      chk("stall_valid", o_valid, 1);
      chk("stall_data", o_data, sd);
      chk("stall_ch", o_ch, sc);
      chk("stall_conv_en", conv_en, 0);
    end
    o_ready = 1'b1;
    run_until_done(500);
    frame_checks(b0);
`ifdef CONV1_PERF_CNT_EN
    chk("stall_cycles", stall_cycles, 10);
`endif

    // Frame 3: random ready.
    frame_tag = 3; b0 = beats_seen; rand_rdy = 1'b1;
    do_start();
    run_until_done(2000);
    rand_rdy = 1'b0; o_ready = 1'b1;
    frame_checks(b0);

    // Overflow: three back-to-back vectors into a stalled buffer.
    conv_on = 1'b0; o_ready = 1'b0; frame_tag = 4;
    do_start();
    conv_valid = 1'b1; conv_data = pix_vec(0); push_exp(0);
    tick();
    conv_data = pix_vec(1); push_exp(1);
    tick();
    conv_data = pix_vec(2);
    tick();
    conv_valid = 1'b0;
    chk("ovf_set", ovf_err, 1);
    chk("ovf_head_valid", o_valid, 1);
    chk("ovf_conv_en", conv_en, 0);
    tick();
    tick();
    chk("ovf_sticky", ovf_err, 1);
    b0 = beats_seen; o_ready = 1'b1;
    repeat (8) tick();
    chk("ovf_beats_no_bubble", beats_seen - b0, 8);
    chk("ovf_sb_empty", sb.size(), 0);
    rst = 1'b1;
    #1;
    chk("rst_clears_ovf", ovf_err, 0);
    tick();
    rst = 1'b0;
    tick();

    // Reset mid-frame: abort, no done pulse.
    conv_on = 1'b1; frame_tag = 5; b0 = beats_seen;
    do_start();
    for (int n = 0; n < 300 && beats_seen - b0 < 10; n++) tick();
    chk("reach_abort_point", beats_seen - b0, 10);
    conv_on = 1'b0; conv_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_outputs", {busy, done, conv_en, o_valid, o_last, ovf_err, o_data, o_ch, o_row, o_col}, '0);
    tick();
    rst = 1'b0;
    sb.delete();
    d0 = done_cnt;
    repeat (20) tick();
    chk("abort_no_done", done_cnt - d0, 0);
    chk("abort_idle", {busy, conv_en, o_valid}, 0);

    // Recovery frame after abort.
    conv_on = 1'b1; frame_tag = 6; b0 = beats_seen;
    do_start();
    run_until_done(500);
    frame_checks(b0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
